tmr_evnt_cond: RTL and testbench
================================

Name: tmr_evnt_cond

Overview:
- Event-input conditioner that sits directly upstream of the Timer block's event logic.
- Takes the raw, asynchronous Evnt pins and applies, per channel: synchroniser, configurable low-pass (glitch) filter, level selection and edge selection.
- Delivers a clean one-cycle edge pulse and a polarity-adjusted level per channel. The Timer's connection matrix consumes these as start/stop/capture/gate/count sources.
- Configuration comes straight from the Timer's ECR register value. It also provides a software-injected event path.

Parameters:
- NEV, 3, number of event channels.
- SYNC_STG, 2, synchroniser flip-flop stages (2 or 3 only).
- CNTW, 3, filter counter width; must hold the largest filter length minus 1.

Ports:
- Clk  in  1  system clock.
- Rst  in  1  reset, asynchronous, active-low (all state cleared while Rst=0).
- Evnt  in  NEV  raw asynchronous event pins (Evnt[0]=Evnt0, and so on).
- Ecr  in  15  ECR register value:
  - [2i+1:2i] edge select of channel i.
  - [6+i] level select of channel i.
  - [10+2i:9+2i] low-pass filter config of channel i.
- SwEv  in  NEV  one-cycle software event strobe from the CPU register write.
- EvEdge  out  NEV  one-cycle detected-edge pulse per channel.
- EvLvl  out  NEV  filtered, polarity-adjusted level per channel.
- EvFilt  out  NEV  filtered raw pin level, for status readback.

Behaviour:
- Synchroniser
  - SYNC_STG-deep flip-flop chain per channel.
  - sync = last stage.
- Filter length N from Ecr LPF field: 00 -> 1 (bypass), 01 -> 3, 10 -> 5, 11 -> 7.
- Filter counter cnt (CNTW bits), per channel, on every clock:
  - sync == filt: cnt <= 0.
  - sync != filt and cnt >= N-1: filt <= sync, cnt <= 0.
  - otherwise: cnt <= cnt+1.
  - Result: filt follows a change only after N consecutive differing samples.
  - A single differing sample shorter than N cycles never reaches filt.
- Latency (SYNC_STG=2): a pin change first sampled at edge k appears on filt at edge k+N+1. Bypass (N=1) gives 2 cycles.
- Edge detection: a change of filt is classified rising (0->1) or falling (1->0) on the filtered pin, independent of level select. Edge select:
  - 00 none.
  - 01 rising.
  - 10 falling.
  - 11 both.
- EvEdge[i] is registered. It asserts in the same cycle filt[i] first shows its new value, for exactly 1 cycle, and only when the change matches the edge select.
- Software path: EvEdge[i] <= (edge match) | SwEv[i].
  - SwEv bypasses the synchroniser and filter, and ignores edge select.
  - Latency is 1 cycle.
  - A simultaneous real edge plus SwEv gives a single 1-cycle pulse; the two are not counted twice.
- Level output: EvLvl[i] = Ecr[6+i] ? filt[i] : ~filt[i]. 1 = active-high. It is combinational from registered filt and Ecr.
- EvFilt = filt.
- Reset values: all sync stages, filt, cnt and EvEdge = 0.
  - EvLvl = ~level_sel at reset, i.e. 1 for an active-low channel.
  - If a pin is high when reset is released, filt rises after N+SYNC_STG cycles and a rising pulse fires if rising is enabled. This is intended.
- Configuration changes mid-operation:
  - Filter length shrink: the >= compare guarantees release on the next differing cycle and no counter overflow.
  - Filter length grow: the current count carries on toward the new N.
  - Edge select change: takes effect for the next filt change. It never creates a pulse by itself.
  - Level select change: EvLvl changes immediately. EvEdge does not pulse.
- Reset asserted mid-filter: the count is discarded, and the channel restarts from filt=0.
- Channels are fully independent. No cross-channel arbitration exists.

Decomposition:
- Package tmr_evnt_pkg holds:
  - edge-select enum (EV_NONE, EV_RISE, EV_FALL, EV_BOTH).
  - LPF enum and the LPF-to-N lookup function.
  - ECR field offset constants (EDGE_OFS=0, LVL_OFS=6, LPF_OFS=9).
- Sub-module tmr_evnt_ch: one channel (synchroniser, filter counter, edge classifier, SwEv merge).
- The top generates NEV instances and slices Ecr per channel.

Test Plan:
- Reset and idle: Rst=0, Evnt=0, Ecr=0 with level select 0 -> EvEdge=000, EvFilt=000, EvLvl=111. After release, everything stays constant for 100 cycles.
- Bypass rising edge: Ecr ch0 edge=01, LPF=00; Evnt0 0->1 -> EvEdge[0] high exactly 1 cycle, 2 cycles after first sampling. A falling edge gives no pulse.
- Filter reject: ch1 LPF=11 (N=7), edge=11:
  - a 6-cycle high glitch -> no EvEdge, EvFilt[1] stays 0.
  - an 8-cycle high pulse -> rising pulse at k+8, then a falling pulse after the return to low.
- Both edges plus level: ch2 edge=11, LPF=01, level=0. Drive the pin at 1000 ns high / 1000 ns low, 10 periods -> 20 EvEdge[2] pulses, and EvLvl[2] is the inverse of EvFilt[2].
- Software event: SwEv=101 for 1 cycle with pins idle -> EvEdge=101 for 1 cycle. Issue SwEv[0] coincident with a real ch0 edge pulse -> a single 1-cycle pulse.
- Mid-operation change:
  - ch0 LPF 11->00 while cnt=4 and the pin differs -> filt updates on the next cycle.
  - Reset asserted during counting -> filt=0, cnt=0 immediately, with no pulse after release if the pin is low.

Source files
------------

// File: rtl/tmr_evnt_pkg.sv
// Shared types and ECR field layout for the timer event-input conditioner.
// Latency: n/a (types, constants and a pure lookup function only).
// Backpressure: n/a.
package tmr_evnt_pkg;

    // ECR register layout
    localparam int ECR_W    = 15;
    localparam int EDGE_OFS = 0;   // 2 bits per channel
    localparam int LVL_OFS  = 6;   // 1 bit per channel
    localparam int LPF_OFS  = 9;   // 2 bits per channel

    // Edge select: bit0 enables rising, bit1 enables falling
    typedef enum logic [1:0] {
        EV_NONE = 2'b00,
        EV_RISE = 2'b01,
        EV_FALL = 2'b10,
        EV_BOTH = 2'b11
    } ev_edge_e;

    // Low-pass filter length select
    typedef enum logic [1:0] {
        LPF_1 = 2'b00,
        LPF_3 = 2'b01,
        LPF_5 = 2'b10,
        LPF_7 = 2'b11
    } ev_lpf_e;

    // Returns N-1: the count a differing sample must reach before filt follows
    function automatic logic [2:0] lpf_last(input ev_lpf_e lpf);
        logic [2:0] last;
        case (lpf)
            LPF_1:   last = 3'd0;
            LPF_3:   last = 3'd2;
            LPF_5:   last = 3'd4;
            default: last = 3'd6;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/tmr_evnt_cond_if.sv
// Pin/config/result bundle between the timer register block and the event conditioner.
// Latency: n/a (wiring only).
// Backpressure: none; every signal is a level or a single-cycle strobe.
interface tmr_evnt_cond_if
    import tmr_evnt_pkg::*;
#(
    parameter int NEV = 3
);
    logic [NEV-1:0]   Evnt;
    logic [ECR_W-1:0] Ecr;
    logic [NEV-1:0]   SwEv;
    logic [NEV-1:0]   EvEdge;
    logic [NEV-1:0]   EvLvl;
    logic [NEV-1:0]   EvFilt;

    modport master (
        output Evnt, Ecr, SwEv,
        input  EvEdge, EvLvl, EvFilt
    );

    modport slave (
        input  Evnt, Ecr, SwEv,
        output EvEdge, EvLvl, EvFilt
    );
endinterface

// File: rtl/tmr_evnt_ch.sv
// One event channel: synchroniser, glitch filter, edge classifier, software event merge.
// Latency: pin->filt SYNC_STG+N-1 cycles after first sample, SwEv->o_edge 1 cycle.
// Backpressure: none; o_edge is a one-cycle pulse that cannot be stalled.
module tmr_evnt_ch
    import tmr_evnt_pkg::*;
#(
    parameter int SYNC_STG = 2,   // 2 or 3
    parameter int CNTW     = 3    // must hold the largest N-1
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    input  logic     i_evnt,
    input  ev_edge_e i_edge_sel,
    input  logic     i_lvl_sel,
    input  ev_lpf_e  i_lpf,
    input  logic     i_sw_ev,
    output logic     o_edge,
    output logic     o_lvl,
    output logic     o_filt
);

    logic [SYNC_STG-1:0] r_sync;
    logic                r_filt;
    logic [CNTW-1:0]     r_cnt;
    logic                r_edge;

    logic                w_sync;
    logic [CNTW-1:0]     w_last;
    logic                w_diff;
    logic                w_rel;
    logic                w_match;

    assign w_sync = r_sync[SYNC_STG-1];
    assign w_last = CNTW'(lpf_last(i_lpf));
    assign w_diff = w_sync ^ r_filt;
    // >= rather than == so a filter shrink mid-count releases on the next differing sample
    assign w_rel  = w_diff && (r_cnt >= w_last);
    // Classify on the value filt is about to take: 1 means rising, 0 means falling
    assign w_match = w_sync ? (i_edge_sel inside {EV_RISE, EV_BOTH})
                            : (i_edge_sel inside {EV_FALL, EV_BOTH});

    // Metastability chain on the raw pin
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_sync <= '0;
        else          r_sync <= {r_sync[SYNC_STG-2:0], i_evnt};
    end

    // Glitch filter: filt follows sync only after N consecutive differing samples
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_filt <= 1'b0;
            r_cnt  <= '0;
        end else if (!w_diff) begin
            r_cnt  <= '0;
        end else if (w_rel) begin
            r_filt <= w_sync;
            r_cnt  <= '0;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    // Edge pulse lands in the same cycle filt shows its new value; SwEv ORs in so a coincident hit is one pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_edge <= 1'b0;
        else          r_edge <= (w_rel && w_match) || i_sw_ev;
    end

    assign o_edge = r_edge;
    assign o_filt = r_filt;
    assign o_lvl  = i_lvl_sel ? r_filt : ~r_filt;

endmodule

// File: rtl/tmr_evnt_cond.sv
// Timer event-input conditioner: NEV independent channels fed from pins, ECR and software strobes.
// Latency: pin->EvFilt/EvEdge SYNC_STG+N-1 cycles after first sample, SwEv->EvEdge 1 cycle.
// Backpressure: none; EvEdge pulses are fire-and-forget to the timer connection matrix.
module tmr_evnt_cond
    import tmr_evnt_pkg::*;
#(
    parameter int NEV      = 3,
    parameter int SYNC_STG = 2,
    parameter int CNTW     = 3
) (
    input  logic                Clk,
    input  logic                Rst,
    tmr_evnt_cond_if.slave      bus
);

    logic [NEV-1:0] w_edge;
    logic [NEV-1:0] w_lvl;
    logic [NEV-1:0] w_filt;

    // One conditioner per channel, each with its own slice of ECR
    for (genvar i = 0; i < NEV; i++) begin : g_ch
        tmr_evnt_ch #(
            .SYNC_STG (SYNC_STG),
            .CNTW     (CNTW)
        ) u_ch (
            .i_clk      (Clk),
            .i_rst_n    (Rst),
            .i_evnt     (bus.Evnt[i]),
            .i_edge_sel (ev_edge_e'(bus.Ecr[EDGE_OFS + 2*i +: 2])),
            .i_lvl_sel  (bus.Ecr[LVL_OFS + i]),
            .i_lpf      (ev_lpf_e'(bus.Ecr[LPF_OFS + 2*i +: 2])),
            .i_sw_ev    (bus.SwEv[i]),
            .o_edge     (w_edge[i]),
            .o_lvl      (w_lvl[i]),
            .o_filt     (w_filt[i])
        );
    end

    assign bus.EvEdge = w_edge;
    assign bus.EvLvl  = w_lvl;
    assign bus.EvFilt = w_filt;

endmodule

// File: tb/tb_tmr_evnt_cond.sv
// Bench for tmr_evnt_cond: expected edge pulses are queued when stimulus is driven and matched on output.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_tmr_evnt_cond;
    import tmr_evnt_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_chk = 0;
    int   n_bad = 0;
    int   pulses2 = 0;

    typedef struct {
        int         cyc;
        logic [2:0] msk;
    } exp_t;
    exp_t sb[$];

    tmr_evnt_cond_if #(.NEV(3)) bus();

    tmr_evnt_cond #(
        .NEV      (3),
        .SYNC_STG (2),
        .CNTW     (3)
    ) dut (
        .Clk (clk),
        .Rst (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // cyc equals the number of rising edges seen so far
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [2:0] m);
        exp_t e;
        e.cyc = c;
        e.msk = m;
        sb.push_back(e);
    endtask

    function automatic logic [14:0] mk_ecr(input ev_edge_e e0, input ev_edge_e e1, input ev_edge_e e2,
                                           input logic [2:0] lvl,
                                           input ev_lpf_e f0, input ev_lpf_e f1, input ev_lpf_e f2);
        return {f2, f1, f0, lvl, e2, e1, e0};
    endfunction

    // Output side of the scoreboard: every EvEdge cycle must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (bus.EvEdge[2] === 1'b1) pulses2++;
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            chk("edge_miss", cyc, sb[0].cyc);
            void'(sb.pop_front());
        end
        if (bus.EvEdge !== 3'b000) begin
            if (sb.size() == 0) begin
                chk("edge_spur", {29'd0, bus.EvEdge}, 0);
            end else begin
                e = sb.pop_front();
                chk("edge_cyc", cyc, e.cyc);
                chk("edge_msk", {29'd0, bus.EvEdge}, {29'd0, e.msk});
            end
        end
    end

    initial begin
        int   nchg;
        int   lvlbad;
        logic seen;

        bus.Evnt = '0;
        bus.Ecr  = '0;
        bus.SwEv = '0;

        // Reset and idle
        repeat (3) @(negedge clk);
        chk("rst_edge", {29'd0, bus.EvEdge}, 0);
        chk("rst_filt", {29'd0, bus.EvFilt}, 0);
        chk("rst_lvl",  {29'd0, bus.EvLvl},  3'b111);
        rst_n = 1'b1;
        nchg = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.EvFilt !== 3'b000 || bus.EvLvl !== 3'b111 || bus.EvEdge !== 3'b000) nchg++;
        end
        chk("idle_stable", nchg, 0);

        // Bypass filter, rising only on ch0: pulse at first-sample edge + 2
        bus.Ecr = mk_ecr(EV_RISE, EV_NONE, EV_NONE, 3'b000, LPF_1, LPF_1, LPF_1);
        repeat (2) @(negedge clk);
        bus.Evnt[0] = 1'b1;
        push(cyc + 3, 3'b001);
        repeat (6) @(negedge clk);
        chk("byp_filt", {29'd0, bus.EvFilt}, 3'b001);
        chk("byp_lvl",  {29'd0, bus.EvLvl},  3'b110);
        bus.Evnt[0] = 1'b0;               // falling edge must not pulse
        repeat (6) @(negedge clk);
        chk("byp_fall_filt", {29'd0, bus.EvFilt}, 0);

        // ch1 N=7 both edges: 6-cycle glitch rejected
        bus.Ecr = mk_ecr(EV_RISE, EV_BOTH, EV_NONE, 3'b000, LPF_1, LPF_7, LPF_1);
        repeat (2) @(negedge clk);
        seen = 1'b0;
        bus.Evnt[1] = 1'b1;
        repeat (6) begin @(negedge clk); seen |= bus.EvFilt[1]; end
        bus.Evnt[1] = 1'b0;
        repeat (12) begin @(negedge clk); seen |= bus.EvFilt[1]; end
        chk("glitch_filt", {31'd0, seen}, 0);

        // ch1 8-cycle pulse passes: rising at k+8, falling after return low
        bus.Evnt[1] = 1'b1;
        push(cyc + 9, 3'b010);
        repeat (8) @(negedge clk);
        chk("lpf7_pre", {31'd0, bus.EvFilt[1]}, 0);
        bus.Evnt[1] = 1'b0;
        push(cyc + 9, 3'b010);
        @(negedge clk);
        chk("lpf7_post", {31'd0, bus.EvFilt[1]}, 1);
        repeat (12) @(negedge clk);
        chk("lpf7_low", {31'd0, bus.EvFilt[1]}, 0);

        // ch2 N=3 both edges, active-low level: 10 periods of 1000ns high / 1000ns low
        bus.Ecr = mk_ecr(EV_RISE, EV_BOTH, EV_BOTH, 3'b000, LPF_1, LPF_7, LPF_3);
        repeat (2) @(negedge clk);
        pulses2 = 0;
        lvlbad  = 0;
        for (int p = 0; p < 10; p++) begin
            bus.Evnt[2] = 1'b1;
            push(cyc + 5, 3'b100);
            repeat (100) begin @(negedge clk); if (bus.EvLvl[2] === bus.EvFilt[2]) lvlbad++; end
            bus.Evnt[2] = 1'b0;
            push(cyc + 5, 3'b100);
            repeat (100) begin @(negedge clk); if (bus.EvLvl[2] === bus.EvFilt[2]) lvlbad++; end
        end
        chk("ch2_pulses", pulses2, 20);
        chk("ch2_lvl_inv", lvlbad, 0);

        // Software event with idle pins: 1-cycle latency, edge select ignored
        bus.SwEv = 3'b101;
        push(cyc + 1, 3'b101);
        @(negedge clk);
        bus.SwEv = 3'b000;
        repeat (4) @(negedge clk);

        // SwEv coincident with a real ch0 rising pulse: single pulse
        bus.Evnt[0] = 1'b1;
        push(cyc + 3, 3'b001);
        repeat (2) @(negedge clk);
        bus.SwEv = 3'b001;
        @(negedge clk);
        bus.SwEv = 3'b000;
        repeat (4) @(negedge clk);
        chk("sw_coinc_filt", {31'd0, bus.EvFilt[0]}, 1);
        bus.Evnt[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk("sw_fall_filt", {31'd0, bus.EvFilt[0]}, 0);

        // Filter shrink 7->1 while cnt=4: release on the next edge
        bus.Ecr = mk_ecr(EV_BOTH, EV_BOTH, EV_BOTH, 3'b000, LPF_7, LPF_7, LPF_3);
        repeat (2) @(negedge clk);
        bus.Evnt[0] = 1'b1;
        repeat (6) @(negedge clk);
        chk("shrink_pre", {31'd0, bus.EvFilt[0]}, 0);
        bus.Ecr = mk_ecr(EV_BOTH, EV_BOTH, EV_BOTH, 3'b000, LPF_1, LPF_7, LPF_3);
        push(cyc + 1, 3'b001);
        @(negedge clk);
        chk("shrink_post", {31'd0, bus.EvFilt[0]}, 1);

        // Reset mid-count: filt clears at once, no pulse after release with pin low
        bus.Ecr = mk_ecr(EV_BOTH, EV_BOTH, EV_BOTH, 3'b000, LPF_7, LPF_7, LPF_3);
        repeat (2) @(negedge clk);
        bus.Evnt[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_mid_pre", {31'd0, bus.EvFilt[0]}, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_filt", {29'd0, bus.EvFilt}, 0);
        chk("rst_mid_edge", {29'd0, bus.EvEdge}, 0);
        chk("rst_mid_lvl",  {29'd0, bus.EvLvl},  3'b111);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("rst_after_filt", {29'd0, bus.EvFilt}, 0);

        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
